// File: rtl/joy_db15_dev_if.sv
// Wire-side and player-word signals of the DB15 joystick link.
// The host (reader or bench) is the master; the emulated adapter chain is the slave.
interface joy_db15_dev_if;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        JOY_DATA;
  logic        frame_done;
  logic        overrun;
  logic        host_active;
  logic [5:0]  bit_cnt;

  modport master (
    output joy1, joy2, JOY_CLK, JOY_LOAD,
    input  JOY_DATA, frame_done, overrun, host_active, bit_cnt
  );

  modport slave (
    input  joy1, joy2, JOY_CLK, JOY_LOAD,
    output JOY_DATA, frame_done, overrun, host_active, bit_cnt
  );
endinterface

// File: rtl/joy_db15_dev.sv
// Device end of the DB15 serial joystick link: a parallel-in/serial-out chain
// that the host loads with JOY_LOAD (active-low) and shifts with JOY_CLK.
// Buttons go out active-low, LSB of {joy2,joy1} first, idle level high.
module joy_db15_dev #(
  parameter int NBITS       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2500000
) (
  input  logic           clk,
  input  logic           reset,
  joy_db15_dev_if.slave  bus
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  // Index 0 is the newest sample; index SYNC_STAGES-1 is the synchronised level and
  // the extra top flop is its one-cycle history used for edge detection.
  logic [SYNC_STAGES:0] clk_sync_reg;
  logic [SYNC_STAGES:0] load_sync_reg;

  logic             clk_lvl, clk_rise;
  logic             load_lvl, load_fall;
  logic [31:0]      pad_word;
  logic [NBITS-1:0] load_word;

  state_t           state_reg;
  logic [NBITS-1:0] shreg_reg;
  logic [5:0]       bit_cnt_reg;
  logic             frame_done_reg;
  logic             overrun_reg;
  logic [WD_W-1:0]  wd_cnt_reg;
  logic             host_active_reg;

  // Bring the host strobes into the clk domain; load idles high, shift clock idles low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_reg  <= '0;
      load_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-1:0], bus.JOY_CLK};
      load_sync_reg <= {load_sync_reg[SYNC_STAGES-1:0], bus.JOY_LOAD};
    end
  end

  assign clk_lvl   = clk_sync_reg[SYNC_STAGES-1];
  assign clk_rise  = clk_lvl & ~clk_sync_reg[SYNC_STAGES];
  assign load_lvl  = load_sync_reg[SYNC_STAGES-1];
  assign load_fall = ~load_lvl & load_sync_reg[SYNC_STAGES];

  // Parallel-load word: inverted buttons, padded with idle-high bits beyond 32.
  assign pad_word = {bus.joy2, bus.joy1};
  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_load
      if (gi < 32) begin : g_btn
        assign load_word[gi] = ~pad_word[gi];
      end else begin : g_pad
        assign load_word[gi] = 1'b1;
      end
    end
  endgenerate

  // Load/shift state machine; load has priority over any shift-clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      shreg_reg      <= '1;
      bit_cnt_reg    <= '0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (!load_lvl) begin
        // Live tracking like a '165 held in load mode.
        state_reg   <= ST_LOAD;
        shreg_reg   <= load_word;
        bit_cnt_reg <= '0;
        overrun_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_LOAD: begin
            // Load strobe has just been released: hold the captured word.
            state_reg <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (clk_rise) begin
              shreg_reg   <= {1'b1, shreg_reg[NBITS-1:1]};
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
              if (bit_cnt_reg + 6'd1 == 6'(NBITS)) begin
                frame_done_reg <= 1'b1;
                state_reg      <= ST_IDLE;
              end
            end
          end
          default: begin
            // Clocks past the end of a frame shift in idle ones and flag an overrun.
            if (clk_rise) begin
              shreg_reg   <= {1'b1, shreg_reg[NBITS-1:1]};
              overrun_reg <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Host-presence watchdog restarted by every load strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_reg      <= '0;
      host_active_reg <= 1'b0;
    end else if (load_fall) begin
      wd_cnt_reg      <= '0;
      host_active_reg <= 1'b1;
    end else if (wd_cnt_reg != WD_W'(TIMEOUT - 1)) begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end else begin
      host_active_reg <= 1'b0;
    end
  end

  assign bus.JOY_DATA    = shreg_reg[0];
  assign bus.frame_done  = frame_done_reg;
  assign bus.overrun     = overrun_reg;
  assign bus.host_active = host_active_reg;
  assign bus.bit_cnt     = bit_cnt_reg;

endmodule

// File: tb/tb_joy_db15_dev.sv
// Directed bench for the DB15 device chain: acts as the host, polls frames and
// checks the serial stream and status outputs against hand-computed values.
module tb_joy_db15_dev;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   fd_cnt;
  int   fd0;
  int   hcnt;
  bit   seen;

  joy_db15_dev_if bus ();

  joy_db15_dev #(.NBITS(32), .SYNC_STAGES(2), .TIMEOUT(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    bus.JOY_LOAD = 1'b0;
    cyc(6);
    bus.JOY_LOAD = 1'b1;
    cyc(6);
  endtask

  task automatic clk_pulse();
    bus.JOY_CLK = 1'b1;
    cyc(5);
    bus.JOY_CLK = 1'b0;
    cyc(5);
  endtask

  initial begin
    logic [31:0] exp_word;
    total = 0;
    bad   = 0;
    fd_cnt = 0;
    reset = 1'b1;
    bus.joy1 = 16'h0000;
    bus.joy2 = 16'h0000;
    bus.JOY_CLK = 1'b0;
    bus.JOY_LOAD = 1'b1;
    cyc(3);
    @(negedge clk);
    check("rst_data", 32'(bus.JOY_DATA), 32'd1);
    check("rst_bitcnt", 32'(bus.bit_cnt), 32'd0);
    check("rst_fdone", 32'(bus.frame_done), 32'd0);
    check("rst_ovr", 32'(bus.overrun), 32'd0);
    check("rst_active", 32'(bus.host_active), 32'd0);
    reset = 1'b0;
    cyc(2);

    // 1: full frame, LSB first, inverted
    bus.joy1 = 16'h0011;
    bus.joy2 = 16'h8000;
    exp_word = 32'h7FFF_FFEE;
    fd0 = fd_cnt;
    do_load();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      check($sformatf("t1_bit%0d", k), 32'(bus.JOY_DATA), 32'(exp_word[k]));
      if (k == 31) check("t1_no_early_fd", 32'(fd_cnt), 32'(fd0));
      #1;
      clk_pulse();
    end
    @(negedge clk);
    check("t1_idle_data", 32'(bus.JOY_DATA), 32'd1);
    check("t1_bitcnt", 32'(bus.bit_cnt), 32'd32);
    check("t1_fd_once", 32'(fd_cnt), 32'(fd0 + 1));
    check("t1_no_ovr", 32'(bus.overrun), 32'd0);
    #1;

    // 2: extra clocks after the frame
    for (int k = 0; k < 3; k++) clk_pulse();
    @(negedge clk);
    check("t2_data", 32'(bus.JOY_DATA), 32'd1);
    check("t2_bitcnt", 32'(bus.bit_cnt), 32'd32);
    check("t2_ovr", 32'(bus.overrun), 32'd1);
    check("t2_fd_none", 32'(fd_cnt), 32'(fd0 + 1));
    #1;
    bus.JOY_LOAD = 1'b0;
    cyc(6);
    @(negedge clk);
    check("t2_ovr_clr", 32'(bus.overrun), 32'd0);
    check("t2_bitcnt_clr", 32'(bus.bit_cnt), 32'd0);
    #1;
    bus.JOY_LOAD = 1'b1;
    cyc(6);

    // 3: abort mid-frame, then a fresh frame
    fd0 = fd_cnt;
    for (int k = 0; k < 10; k++) clk_pulse();
    @(negedge clk);
    check("t3_bitcnt10", 32'(bus.bit_cnt), 32'd10);
    #1;
    bus.joy1 = 16'hFFFF;
    bus.joy2 = 16'hA5C3;
    bus.JOY_LOAD = 1'b0;
    cyc(6);
    @(negedge clk);
    check("t3_abort_bitcnt", 32'(bus.bit_cnt), 32'd0);
    check("t3_abort_no_fd", 32'(fd_cnt), 32'(fd0));
    #1;
    bus.JOY_LOAD = 1'b1;
    cyc(6);
    exp_word = 32'h5A3C_0000;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      check($sformatf("t3_bit%0d", k), 32'(bus.JOY_DATA), 32'(exp_word[k]));
      #1;
      clk_pulse();
    end
    @(negedge clk);
    check("t3_fd_once", 32'(fd_cnt), 32'(fd0 + 1));
    #1;

    // 4: live tracking during load
    bus.joy1 = 16'h0000;
    bus.joy2 = 16'h0000;
    bus.JOY_LOAD = 1'b0;
    cyc(6);
    @(negedge clk);
    check("t4_before", 32'(bus.JOY_DATA), 32'd1);
    @(posedge clk);
    #1;
    bus.joy1 = 16'h0001;
    cyc(2);
    @(negedge clk);
    check("t4_tracked", 32'(bus.JOY_DATA), 32'd0);
    #1;
    bus.JOY_LOAD = 1'b1;
    cyc(6);
    @(negedge clk);
    check("t4_held", 32'(bus.JOY_DATA), 32'd0);
    #1;
    clk_pulse();
    @(negedge clk);
    check("t4_bit1", 32'(bus.JOY_DATA), 32'd1);
    #1;

    // 5: load and clock edge together -> load wins
    do_load();
    clk_pulse();
    clk_pulse();
    @(negedge clk);
    check("t5_pre_bitcnt", 32'(bus.bit_cnt), 32'd2);
    #1;
    bus.JOY_LOAD = 1'b0;
    bus.JOY_CLK = 1'b1;
    cyc(6);
    @(negedge clk);
    check("t5_bitcnt", 32'(bus.bit_cnt), 32'd0);
    #1;
    bus.JOY_CLK = 1'b0;
    cyc(6);
    bus.JOY_LOAD = 1'b1;
    cyc(6);
    @(negedge clk);
    check("t5_post_bitcnt", 32'(bus.bit_cnt), 32'd0);
    check("t5_post_data", 32'(bus.JOY_DATA), 32'd0);
    #1;

    // 6: watchdog with TIMEOUT=100
    cyc(120);
    @(negedge clk);
    check("t6_idle_inactive", 32'(bus.host_active), 32'd0);
    hcnt = 0;
    seen = 1'b0;
    bus.JOY_LOAD = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 6) bus.JOY_LOAD = 1'b1;
      if (bus.host_active === 1'b1) begin
        hcnt++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    check("t6_active_cycles", 32'(hcnt), 32'd100);
    check("t6_dropped", 32'(bus.host_active), 32'd0);
    #1;

    // 6b: reset mid-frame
    bus.joy1 = 16'h0020;
    bus.joy2 = 16'h0000;
    do_load();
    for (int k = 0; k < 5; k++) clk_pulse();
    @(negedge clk);
    check("t6_pre_rst_data", 32'(bus.JOY_DATA), 32'd0);
    check("t6_pre_rst_bitcnt", 32'(bus.bit_cnt), 32'd5);
    reset = 1'b1;
    #1;
    check("t6_rst_data", 32'(bus.JOY_DATA), 32'd1);
    check("t6_rst_bitcnt", 32'(bus.bit_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(2);
    clk_pulse();
    @(negedge clk);
    check("t6_norel_data", 32'(bus.JOY_DATA), 32'd1);
    check("t6_norel_bitcnt", 32'(bus.bit_cnt), 32'd0);
    check("t6_norel_ovr", 32'(bus.overrun), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
